fwd_producer: RTL and testbench

Produces the forwarding packages consumed by the EX-stage operand selection, and owns the EX→MEM and MEM→WB result registers. Tracks the destination of each in-flight instruction through MEM and WB. Publishes one `fwd_t` per stage and drives the regfile write port from WB. Detects load-use hazards against the EX-stage consumer and raises a one-cycle stall.

---
 rtl/fwd_producer_pkg.sv | 31 +++
 rtl/load_use_detector.sv | 27 ++
 rtl/fwd_producer.sv | 103 ++++++++++
 tb/tb_fwd_producer.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_producer_pkg.sv
// Forwarding types shared by the EX/MEM/WB result path.
// Stage records, forward packages and the x0 constant.
package fwd_producer_pkg;

  localparam int XLEN = 32;
  localparam int RW   = 5;

  localparam logic [RW-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [RW-1:0]   fwd_rd_addr;
    logic [XLEN-1:0] fwd_rd_data;
    logic            fwd_allow;
  } fwd_t;

  typedef struct packed {
    logic            valid;
    logic            wren;
    logic            load;
    logic [RW-1:0]   rd_addr;
    logic [XLEN-1:0] rd_data;
  } stage_rec_t;

  localparam stage_rec_t REC_NONE = '0;

  // A record that will really update a register other than x0.
  function automatic logic rec_live(stage_rec_t r);
    return r.valid & r.wren & (r.rd_addr != REG_ZERO);
  endfunction

endpackage

// File: rtl/load_use_detector.sv
// Load-use hazard check: a load in MEM feeding an EX source.
// Purely combinational; a flushed EX instruction never stalls.
module load_use_detector
  import fwd_producer_pkg::*;
(
  input  stage_rec_t        mem_rec_i,
  input  logic              ex_valid_i,
  input  logic              flush_i,
  input  logic [RW-1:0]     rs1_addr_i,
  input  logic [RW-1:0]     rs2_addr_i,
  input  logic              use_rs1_i,
  input  logic              use_rs2_i,
  output logic              stall_o
);

  logic hit1;
  logic hit2;

  // Stall when a live load in MEM targets a source EX reads.
  always_comb begin
    hit1    = use_rs1_i & (rs1_addr_i == mem_rec_i.rd_addr);
    hit2    = use_rs2_i & (rs2_addr_i == mem_rec_i.rd_addr);
    stall_o = rec_live(mem_rec_i) & mem_rec_i.load
            & ex_valid_i & ~flush_i & (hit1 | hit2);
  end

endmodule

// File: rtl/fwd_producer.sv
// EX->MEM->WB result registers, forward packages, regfile port.
// FWD_STATS_EN adds o_stall_cnt, a wrapping stall-cycle counter.
module fwd_producer
  import fwd_producer_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_ex_valid,
  input  logic            i_ex_wren,
  input  logic            i_ex_load_en,
  input  logic [RW-1:0]   i_ex_rd_addr,
  input  logic [XLEN-1:0] i_ex_rd_data,
  input  logic [RW-1:0]   i_ex_rs1_addr,
  input  logic [RW-1:0]   i_ex_rs2_addr,
  input  logic            i_ex_use_rs1,
  input  logic            i_ex_use_rs2,
  input  logic            i_flush,
  input  logic [XLEN-1:0] i_lsu_rdata,
  output fwd_t            o_mem_fwd_pkg,
  output fwd_t            o_wb_fwd_pkg,
  output logic            o_stall,
  output logic            o_rf_wren,
  output logic [RW-1:0]   o_rf_rd_addr,
`ifdef FWD_STATS_EN
  output logic [XLEN-1:0] o_stall_cnt,
`endif
  output logic [XLEN-1:0] o_rf_rd_data
);

  stage_rec_t mem_q;
  stage_rec_t mem_d;
  stage_rec_t wb_q;
  logic       stall;

  load_use_detector u_lud (
    .mem_rec_i  (mem_q),
    .ex_valid_i (i_ex_valid),
    .flush_i    (i_flush),
    .rs1_addr_i (i_ex_rs1_addr),
    .rs2_addr_i (i_ex_rs2_addr),
    .use_rs1_i  (i_ex_use_rs1),
    .use_rs2_i  (i_ex_use_rs2),
    .stall_o    (stall)
  );

  // Next MEM entry: EX result, or a bubble on kill/stall/idle.
  always_comb begin
    mem_d = REC_NONE;
    if (i_ex_valid & ~i_flush & ~stall) begin
      mem_d.valid   = 1'b1;
      mem_d.wren    = i_ex_wren;
      mem_d.load    = i_ex_load_en;
      mem_d.rd_addr = i_ex_rd_addr;
      mem_d.rd_data = i_ex_rd_data;
    end
  end

  // Stage registers; WB simply follows MEM every cycle.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      mem_q <= REC_NONE;
      wb_q  <= REC_NONE;
    end else begin
      mem_q <= mem_d;
      wb_q  <= mem_q;
    end
  end

  // Forward packages and regfile port; MEM loads never forward.
  always_comb begin
    o_mem_fwd_pkg.fwd_allow   = rec_live(mem_q) & ~mem_q.load;
    o_mem_fwd_pkg.fwd_rd_addr = mem_q.rd_addr;
    o_mem_fwd_pkg.fwd_rd_data = mem_q.rd_data;
    o_wb_fwd_pkg.fwd_allow    = rec_live(wb_q);
    o_wb_fwd_pkg.fwd_rd_addr  = wb_q.rd_addr;
    o_wb_fwd_pkg.fwd_rd_data  = wb_q.load ? i_lsu_rdata
                                          : wb_q.rd_data;
    o_rf_wren    = o_wb_fwd_pkg.fwd_allow;
    o_rf_rd_addr = o_wb_fwd_pkg.fwd_rd_addr;
    o_rf_rd_data = o_wb_fwd_pkg.fwd_rd_data;
    o_stall      = stall;
  end

`ifdef FWD_STATS_EN
  logic [XLEN-1:0] cnt_q;
  logic [XLEN-1:0] cnt_d;

  // Count stall cycles, wrapping naturally at 2^32.
  always_comb begin
    cnt_d = cnt_q;
    if (stall) cnt_d = cnt_q + 32'd1;
  end

  // Counter register, held at zero while in reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign o_stall_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_fwd_producer.sv
// Bench for fwd_producer: directed table plus randomized model.
// Build with FWD_STATS_EN to also exercise o_stall_cnt.
module tb_fwd_producer;
  import fwd_producer_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_wren, ex_load;
  logic [4:0]  ex_rd, rs1, rs2;
  logic [31:0] ex_data, lsu;
  logic        use1, use2, flush;
  fwd_t        mem_pkg, wb_pkg;
  logic        stall, rf_wren;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
`ifdef FWD_STATS_EN
  logic [31:0] stall_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fwd_producer dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_ex_valid    (ex_valid),
    .i_ex_wren     (ex_wren),
    .i_ex_load_en  (ex_load),
    .i_ex_rd_addr  (ex_rd),
    .i_ex_rd_data  (ex_data),
    .i_ex_rs1_addr (rs1),
    .i_ex_rs2_addr (rs2),
    .i_ex_use_rs1  (use1),
    .i_ex_use_rs2  (use2),
    .i_flush       (flush),
    .i_lsu_rdata   (lsu),
    .o_mem_fwd_pkg (mem_pkg),
    .o_wb_fwd_pkg  (wb_pkg),
    .o_stall       (stall),
    .o_rf_wren     (rf_wren),
    .o_rf_rd_addr  (rf_addr),
`ifdef FWD_STATS_EN
    .o_stall_cnt   (stall_cnt),
`endif
    .o_rf_rd_data  (rf_data)
  );

  typedef struct packed {
    logic        v, w, ld;
    logic [4:0]  rd;
    logic [31:0] d;
    logic [4:0]  rs1, rs2;
    logic        u1, u2, fl;
  } ex_t;

  typedef struct packed {
    logic        st;
    logic        ma;
    logic [4:0]  mad;
    logic [31:0] mdt;
    logic        wa;
    logic [4:0]  wad;
    logic [31:0] wdt;
  } exp_t;

  typedef struct packed {
    logic        chk;
    logic        rst;
    ex_t         ex;
    logic [31:0] lsu;
    exp_t        e;
  } vec_t;

  function automatic ex_t alu(logic [4:0] rd, logic [31:0] d);
    ex_t r = '0;
    r.v = 1'b1; r.w = 1'b1; r.rd = rd; r.d = d;
    return r;
  endfunction

  function automatic ex_t lod(logic [4:0] rd);
    ex_t r = alu(rd, 32'd0);
    r.ld = 1'b1;
    return r;
  endfunction

  function automatic ex_t usr(logic [4:0] a, logic [4:0] b,
                              logic u1, logic u2, logic [4:0] rd,
                              logic [31:0] d, logic fl);
    ex_t r = alu(rd, d);
    r.rs1 = a; r.rs2 = b; r.u1 = u1; r.u2 = u2; r.fl = fl;
    return r;
  endfunction

  function automatic exp_t ee(logic st, logic ma, logic [4:0] mad,
                              logic [31:0] mdt, logic wa,
                              logic [4:0] wad, logic [31:0] wdt);
    exp_t r;
    r.st = st; r.ma = ma; r.mad = mad; r.mdt = mdt;
    r.wa = wa; r.wad = wad; r.wdt = wdt;
    return r;
  endfunction

  function automatic vec_t vr(logic c, logic r, ex_t x,
                              logic [31:0] l, exp_t e);
    vec_t v;
    v.chk = c; v.rst = r; v.ex = x; v.lsu = l; v.e = e;
    return v;
  endfunction

  task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(ex_t x, logic r, logic [31:0] l);
    rst_n    = ~r;
    ex_valid = x.v;
    ex_wren  = x.w;
    ex_load  = x.ld;
    ex_rd    = x.rd;
    ex_data  = x.d;
    rs1      = x.rs1;
    rs2      = x.rs2;
    use1     = x.u1;
    use2     = x.u2;
    flush    = x.fl;
    lsu      = l;
  endtask

  // Reference model: each stage holds "what this instruction will
  // write", reduced to whether it really writes a nonzero register.
  typedef struct {
    bit          wr;
    bit          ld;
    logic [4:0]  rd;
    logic [31:0] d;
  } ent_t;

  ent_t m_mem, m_wb;
  bit   m_ok = 0;
  int   m_cnt = 0;
  bit   m_st;

  task automatic step(ex_t x, logic r, logic [31:0] l);
    ent_t nx;
    logic [31:0] wd;
    drive(x, r, l);
    #1;
    m_st = m_mem.wr && m_mem.ld && x.v && !x.fl &&
           ((x.u1 && x.rs1 == m_mem.rd) ||
            (x.u2 && x.rs2 == m_mem.rd));
    wd = m_wb.ld ? l : m_wb.d;
    if (m_ok) begin
      cmp("stall", stall, m_st);
      cmp("mem_allow", mem_pkg.fwd_allow, m_mem.wr && !m_mem.ld);
      if (m_mem.wr && !m_mem.ld) begin
        cmp("mem_addr", mem_pkg.fwd_rd_addr, m_mem.rd);
        cmp("mem_data", mem_pkg.fwd_rd_data, m_mem.d);
      end
      cmp("wb_allow", wb_pkg.fwd_allow, m_wb.wr);
      cmp("rf_wren", rf_wren, m_wb.wr);
      if (m_wb.wr) begin
        cmp("wb_addr", wb_pkg.fwd_rd_addr, m_wb.rd);
        cmp("wb_data", wb_pkg.fwd_rd_data, wd);
        cmp("rf_addr", rf_addr, m_wb.rd);
        cmp("rf_data", rf_data, wd);
      end
`ifdef FWD_STATS_EN
      cmp("stall_cnt_run", stall_cnt, m_cnt);
`endif
    end
    @(posedge clk);
    nx = '{wr: 0, ld: 0, rd: 0, d: 0};
    if (x.v && !x.fl && !m_st) begin
      nx.wr = x.w && (x.rd != 0);
      nx.ld = x.ld;
      nx.rd = x.rd;
      nx.d  = x.d;
    end
    if (r) begin
      m_mem = '{wr: 0, ld: 0, rd: 0, d: 0};
      m_wb  = '{wr: 0, ld: 0, rd: 0, d: 0};
      m_cnt = 0;
      m_ok  = 1;
    end else begin
      m_wb  = m_mem;
      m_mem = nx;
      if (m_st) m_cnt++;
    end
    #1;
  endtask

  vec_t tbl [21];
  exp_t z;
  ex_t  bub;

  initial begin
    ex_t cur;
    bit  held;
    z   = '0;
    bub = '0;
    tbl[0]  = vr(0, 1, alu(5, 32'h5), 0, z);
    tbl[1]  = vr(1, 1, alu(5, 32'h5), 0, z);
    tbl[2]  = vr(1, 1, alu(5, 32'h5), 0, z);
    tbl[3]  = vr(1, 0, alu(5, 32'h1234), 0, z);
    tbl[4]  = vr(1, 0, bub, 0, ee(0, 1, 5, 32'h1234, 0, 0, 0));
    tbl[5]  = vr(1, 0, bub, 0, ee(0, 0, 0, 0, 1, 5, 32'h1234));
    tbl[6]  = vr(1, 0, lod(7), 0, z);
    tbl[7]  = vr(1, 0, usr(0, 7, 0, 1, 8, 32'h55, 0), 0,
                 ee(1, 0, 7, 0, 0, 0, 0));
    tbl[8]  = vr(1, 0, usr(0, 7, 0, 1, 8, 32'h55, 0), 32'hDEADBEEF,
                 ee(0, 0, 0, 0, 1, 7, 32'hDEADBEEF));
    tbl[9]  = vr(1, 0, bub, 0, ee(0, 1, 8, 32'h55, 0, 0, 0));
    tbl[10] = vr(1, 0, alu(0, 32'h99), 0,
                 ee(0, 0, 0, 0, 1, 8, 32'h55));
    tbl[11] = vr(1, 0, lod(0), 0, ee(0, 0, 0, 32'h99, 0, 0, 0));
    tbl[12] = vr(1, 0, usr(0, 0, 1, 0, 9, 32'h77, 0), 0,
                 ee(0, 0, 0, 0, 0, 0, 32'h99));
    tbl[13] = vr(1, 0, lod(3), 32'hAAAA,
                 ee(0, 1, 9, 32'h77, 0, 0, 32'hAAAA));
    tbl[14] = vr(1, 0, usr(3, 0, 1, 0, 4, 32'h44, 1), 0,
                 ee(0, 0, 3, 0, 1, 9, 32'h77));
    tbl[15] = vr(1, 0, bub, 32'h3333,
                 ee(0, 0, 0, 0, 1, 3, 32'h3333));
    tbl[16] = vr(1, 0, bub, 0, z);
    tbl[17] = vr(1, 0, alu(6, 32'h66), 0, z);
    tbl[18] = vr(1, 1, bub, 0, ee(0, 1, 6, 32'h66, 0, 0, 0));
    tbl[19] = vr(1, 0, bub, 0, z);
    tbl[20] = vr(1, 0, bub, 0, z);

    for (int i = 0; i < 21; i++) begin
      drive(tbl[i].ex, tbl[i].rst, tbl[i].lsu);
      #1;
      if (tbl[i].chk) begin
        cmp($sformatf("r%0d_stall", i), stall, tbl[i].e.st);
        cmp($sformatf("r%0d_mallow", i), mem_pkg.fwd_allow,
            tbl[i].e.ma);
        cmp($sformatf("r%0d_maddr", i), mem_pkg.fwd_rd_addr,
            tbl[i].e.mad);
        cmp($sformatf("r%0d_mdata", i), mem_pkg.fwd_rd_data,
            tbl[i].e.mdt);
        cmp($sformatf("r%0d_wallow", i), wb_pkg.fwd_allow,
            tbl[i].e.wa);
        cmp($sformatf("r%0d_waddr", i), wb_pkg.fwd_rd_addr,
            tbl[i].e.wad);
        cmp($sformatf("r%0d_wdata", i), wb_pkg.fwd_rd_data,
            tbl[i].e.wdt);
        cmp($sformatf("r%0d_rfwren", i), rf_wren, tbl[i].e.wa);
      end
      @(posedge clk);
      #1;
    end

    // Three separate load-use events, then reset.
    step(bub, 1, 0);
`ifdef FWD_STATS_EN
    cmp("stall_cnt_reset0", stall_cnt, 32'd0);
`endif
    for (int k = 0; k < 3; k++) begin
      step(lod(7), 0, 0);
      step(usr(7, 0, 1, 0, 8, 32'h1, 0), 0, 32'h70 + k);
      step(usr(7, 0, 1, 0, 8, 32'h1, 0), 0, 32'h70 + k);
      step(bub, 0, 0);
    end
`ifdef FWD_STATS_EN
    cmp("stall_cnt_three", stall_cnt, 32'd3);
`endif
    step(bub, 1, 0);
`ifdef FWD_STATS_EN
    cmp("stall_cnt_cleared", stall_cnt, 32'd0);
`endif

    // Randomized traffic; EX held steady while stalled.
    held = 0;
    cur  = '0;
    for (int n = 0; n < 400; n++) begin
      logic r;
      if (!held) begin
        cur.v   = ($urandom % 4) != 0;
        cur.w   = ($urandom % 4) != 0;
        cur.ld  = ($urandom % 3) == 0;
        cur.rd  = 5'($urandom % 4);
        cur.d   = $urandom;
        cur.rs1 = 5'($urandom % 4);
        cur.rs2 = 5'($urandom % 4);
        cur.u1  = 1'($urandom % 2);
        cur.u2  = 1'($urandom % 2);
        cur.fl  = ($urandom % 8) == 0;
      end
      r = ($urandom % 50) == 0;
      step(cur, r, $urandom);
      held = m_st && !r;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
